// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
//   Shared constants for the memory-stage access controller:
//   - MIPS memory op codes as produced by the execute stage
//   - data bus transfer size encodings (SIZE_BYTE/HALF/WORD)
//   - FSM state encoding
//   - helpers that turn an op code or byte-select into a bus size
package mem_access_ctrl_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Loads carry their width in the op code.
  function automatic logic [1:0] load_size(input logic [7:0] op);
    case (op)
      EXE_LW_OP:             load_size = SIZE_WORD;
      EXE_LH_OP, EXE_LHU_OP: load_size = SIZE_HALF;
      default:               load_size = SIZE_BYTE;
    endcase
  endfunction

  // Stores carry their width in the byte-select pattern.
  function automatic logic [1:0] store_size(input logic [3:0] sel);
    case (sel)
      4'b1111:          store_size = SIZE_WORD;
      4'b0011, 4'b1100: store_size = SIZE_HALF;
      default:          store_size = SIZE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// load_extend
//   Purely combinational load-result formatter. Picks the addressed byte or
//   halfword out of the bus read word and sign- or zero-extends it.
//   Ports:
//     op      in  8   latched load op code
//     addr_lo in  2   latched effective address bits [1:0]
//     rdata   in  32  raw bus read data
//     ext     out 32  extended result for writeback
module load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    ext = rdata;
    case (op)
      EXE_LB_OP:  ext = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP: ext = {24'd0, byte_sel};
      EXE_LH_OP:  ext = {{16{half_sel[15]}}, half_sel};
      EXE_LHU_OP: ext = {16'd0, half_sel};
      default:    ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Memory-stage access controller. Captures one load/store from the execute
//   stage, runs it on the SRAM-like bus (req / addr_ok / data_ok), stalls the
//   pipeline until the bus finishes and returns the extended load result.
//   Optional macro: MEM_UNALIGN_EXC_EN -- misaligned LW/LH/LHU/SW/SH raise
//   adel/ades in E and never start a transaction. Without it the flags are 0
//   and misaligned loads are issued word-aligned.
//   Ports:
//     clk, resetn                  clock, async active-low reset
//     mem_validE, alucontrolE      E-stage memory op valid and op code
//     aluoutE, selE, wdataE        address, byte-select, replicated data
//     flushM                       discard result of in-flight access
//     data_req/wr/size/addr/wdata  bus request side
//     data_addr_ok/data_ok/rdata   bus response side
//     stall_mem                    hold earlier stages
//     resultM, result_valid        load result and completion pulse
//     adel, ades                   misaligned load/store flags
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_validE,
  input  logic [7:0]        alucontrolE,
  input  logic [ADDR_W-1:0] aluoutE,
  input  logic [3:0]        selE,
  input  logic [DATA_W-1:0] wdataE,
  input  logic              flushM,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              stall_mem,
  output logic [DATA_W-1:0] resultM,
  output logic              result_valid,
  output logic              adel,
  output logic              ades
);

  state_t      state_q, state_d;
  logic        is_load_op, is_store_op;
  logic        mis_word, mis_half, mis_load;
  logic        accept, complete, kill_q, kill_now;
  logic [7:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [ADDR_W-1:0] bus_addr_e;
  logic [31:0] ext_data;

  always_comb begin
    is_load_op  = 1'b0;
    is_store_op = 1'b0;
    case (alucontrolE)
      EXE_LW_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LB_OP, EXE_LBU_OP: is_load_op  = 1'b1;
      EXE_SW_OP, EXE_SH_OP, EXE_SB_OP:                         is_store_op = 1'b1;
      default: ;
    endcase
  end

  assign mis_word = (aluoutE[1:0] != 2'b00);
  assign mis_half = aluoutE[0];
  assign mis_load = ((alucontrolE == EXE_LW_OP) && mis_word) ||
                    (((alucontrolE == EXE_LH_OP) || (alucontrolE == EXE_LHU_OP)) && mis_half);

`ifdef MEM_UNALIGN_EXC_EN
  assign adel = mem_validE && mis_load;
  assign ades = mem_validE && (((alucontrolE == EXE_SW_OP) && mis_word) ||
                               ((alucontrolE == EXE_SH_OP) && mis_half));
`else
  assign adel = 1'b0;
  assign ades = 1'b0;
`endif

  // Misaligned loads only reach the bus when the exception is disabled; they
  // are then fetched from the containing word.
  assign bus_addr_e = mis_load ? {aluoutE[ADDR_W-1:2], 2'b00} : aluoutE;

  // A store whose byte-select came out empty has nothing to write.
  assign accept = (state_q == S_IDLE) && mem_validE && !flushM && !adel && !ades &&
                  (is_load_op || (is_store_op && (selE != 4'b0000)));

  assign stall_mem = (state_q != S_IDLE) || accept;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    data_req = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = S_REQ;
      S_REQ: begin
        data_req = 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: if (data_data_ok) begin
        complete = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A flush arriving in the completion cycle itself still kills the result.
  assign kill_now = kill_q || flushM;

  load_extend u_load_extend (
    .op      (op_q),
    .addr_lo (addr_lo_q),
    .rdata   (data_rdata),
    .ext     (ext_data)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_wr      <= 1'b0;
      data_size    <= SIZE_BYTE;
      data_addr    <= '0;
      data_wdata   <= '0;
      op_q         <= 8'd0;
      addr_lo_q    <= 2'd0;
      kill_q       <= 1'b0;
      result_valid <= 1'b0;
      resultM      <= '0;
    end else begin
      if (accept) begin
        data_wr    <= is_store_op;
        data_size  <= is_store_op ? store_size(selE) : load_size(alucontrolE);
        data_addr  <= bus_addr_e;
        data_wdata <= wdataE;
        op_q       <= alucontrolE;
        addr_lo_q  <= aluoutE[1:0];
      end

      if (complete)                                kill_q <= 1'b0;
      else if ((state_q != S_IDLE) && flushM)      kill_q <= 1'b1;

      result_valid <= complete && !kill_now;
      if (complete && !kill_now && !data_wr) resultM <= ext_data;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl. Inputs change on the falling edge and
//   outputs are sampled on the falling edge (or 1ns after it for the
//   combinational accept-cycle signals).
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_validE;
  logic [7:0]  alucontrolE;
  logic [31:0] aluoutE;
  logic [3:0]  selE;
  logic [31:0] wdataE;
  logic        flushM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        stall_mem;
  logic [31:0] resultM;
  logic        result_valid, adel, ades;

  int pass_cnt = 0;
  int total_cnt = 0;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .mem_validE(mem_validE), .alucontrolE(alucontrolE),
    .aluoutE(aluoutE), .selE(selE), .wdataE(wdataE), .flushM(flushM),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .stall_mem(stall_mem),
    .resultM(resultM), .result_valid(result_valid), .adel(adel), .ades(ades)
  );

  always #5 clk = ~clk;

  // Runs one access with both bus acks in the first REQ cycle. Called on a
  // falling edge; returns on the falling edge after completion.
  task automatic do_access(input logic [7:0] op, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] wdata,
                           input logic [31:0] rdata,
                           output logic rv, output logic [31:0] res);
    mem_validE = 1'b1; alucontrolE = op; aluoutE = addr; selE = sel; wdataE = wdata;
    @(negedge clk);
    mem_validE = 1'b0; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = rdata;
    @(negedge clk);
    rv = result_valid; res = resultM;
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (data_req !== 1'b0) $display("[TB] FAIL rst_req: got %b want 0", data_req); else pass_cnt++;
    total_cnt++; if (stall_mem !== 1'b0) $display("[TB] FAIL rst_stall: got %b want 0", stall_mem); else pass_cnt++;
    total_cnt++; if (result_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b want 0", result_valid); else pass_cnt++;
    total_cnt++; if (resultM !== 32'h0) $display("[TB] FAIL rst_result: got %h want 0", resultM); else pass_cnt++;
    total_cnt++; if ({data_wr, data_size, data_addr} !== 35'h0) $display("[TB] FAIL rst_bus: got %b/%h/%h want 0", data_wr, data_size, data_addr); else pass_cnt++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw;
    mem_validE = 1'b1; alucontrolE = EXE_LW_OP; aluoutE = 32'h1000; selE = 4'b0000;
    #1;
    total_cnt++; if (stall_mem !== 1'b1) $display("[TB] FAIL lw_stall_accept: got %b want 1", stall_mem); else pass_cnt++;
    @(negedge clk);
    mem_validE = 1'b0;
    total_cnt++; if (data_req !== 1'b1) $display("[TB] FAIL lw_req: got %b want 1", data_req); else pass_cnt++;
    total_cnt++; if (data_addr !== 32'h1000) $display("[TB] FAIL lw_addr: got %h want 00001000", data_addr); else pass_cnt++;
    total_cnt++; if ({data_wr, data_size} !== 3'b0_10) $display("[TB] FAIL lw_wr_size: got %b/%0d want 0/2", data_wr, data_size); else pass_cnt++;
    total_cnt++; if (stall_mem !== 1'b1) $display("[TB] FAIL lw_stall_req: got %b want 1", stall_mem); else pass_cnt++;
    total_cnt++; if (result_valid !== 1'b0) $display("[TB] FAIL lw_early_valid: got %b want 0", result_valid); else pass_cnt++;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h80FF7F01;
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    total_cnt++; if (result_valid !== 1'b1) $display("[TB] FAIL lw_valid: got %b want 1", result_valid); else pass_cnt++;
    total_cnt++; if (resultM !== 32'h80FF7F01) $display("[TB] FAIL lw_result: got %h want 80ff7f01", resultM); else pass_cnt++;
    total_cnt++; if (stall_mem !== 1'b0 || data_req !== 1'b0) $display("[TB] FAIL lw_done_idle: got stall=%b req=%b want 0/0", stall_mem, data_req); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (result_valid !== 1'b0) $display("[TB] FAIL lw_pulse_width: got %b want 0", result_valid); else pass_cnt++;
  endtask

  task automatic test_byte_half;
    logic rv; logic [31:0] res;
    do_access(EXE_LB_OP, 32'h1003, 4'b0, 32'h0, 32'h80FF7F01, rv, res);
    total_cnt++; if (rv !== 1'b1 || res !== 32'hFFFFFF80) $display("[TB] FAIL lb_1003: got %b/%h want 1/ffffff80", rv, res); else pass_cnt++;
    do_access(EXE_LBU_OP, 32'h1003, 4'b0, 32'h0, 32'h80FF7F01, rv, res);
    total_cnt++; if (rv !== 1'b1 || res !== 32'h00000080) $display("[TB] FAIL lbu_1003: got %b/%h want 1/00000080", rv, res); else pass_cnt++;
    do_access(EXE_LB_OP, 32'h1002, 4'b0, 32'h0, 32'h80FF7F01, rv, res);
    total_cnt++; if (res !== 32'hFFFFFFFF) $display("[TB] FAIL lb_1002: got %h want ffffffff", res); else pass_cnt++;
    do_access(EXE_LH_OP, 32'h1000, 4'b0, 32'h0, 32'h80FF7F01, rv, res);
    total_cnt++; if (res !== 32'h00007F01) $display("[TB] FAIL lh_1000: got %h want 00007f01", res); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic rv; logic [31:0] res;
    do_access(EXE_LBU_OP, 32'h1001, 4'b0, 32'h0, 32'h80FF7F01, rv, res);
    total_cnt++; if (rv !== 1'b1 || res !== 32'h0000007F) $display("[TB] FAIL b2b_lbu: got %b/%h want 1/0000007f", rv, res); else pass_cnt++;
    do_access(EXE_LH_OP, 32'h1002, 4'b0, 32'h0, 32'h80FF7F01, rv, res);
    total_cnt++; if (rv !== 1'b1 || res !== 32'hFFFF80FF) $display("[TB] FAIL b2b_lh: got %b/%h want 1/ffff80ff", rv, res); else pass_cnt++;
    do_access(EXE_LHU_OP, 32'h1002, 4'b0, 32'h0, 32'h80FF7F01, rv, res);
    total_cnt++; if (rv !== 1'b1 || res !== 32'h000080FF) $display("[TB] FAIL b2b_lhu: got %b/%h want 1/000080ff", rv, res); else pass_cnt++;
  endtask

  task automatic test_sh;
    logic rv; logic [31:0] res;
    do_access(EXE_LW_OP, 32'h3000, 4'b0, 32'h0, 32'hCAFEF00D, rv, res);
    mem_validE = 1'b1; alucontrolE = EXE_SH_OP; aluoutE = 32'h2002; selE = 4'b1100; wdataE = 32'hBEEFBEEF;
    @(negedge clk);
    mem_validE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total_cnt++; if (data_req !== 1'b1 || data_addr !== 32'h2002) $display("[TB] FAIL sh_hold_%0d: got req=%b addr=%h want 1/00002002", i, data_req, data_addr); else pass_cnt++;
      @(negedge clk);
    end
    data_addr_ok = 1'b1;
    total_cnt++; if (data_req !== 1'b1) $display("[TB] FAIL sh_req_ack: got %b want 1", data_req); else pass_cnt++;
    total_cnt++; if ({data_wr, data_size} !== 3'b1_01) $display("[TB] FAIL sh_wr_size: got %b/%0d want 1/1", data_wr, data_size); else pass_cnt++;
    total_cnt++; if (data_wdata !== 32'hBEEFBEEF) $display("[TB] FAIL sh_wdata: got %h want beefbeef", data_wdata); else pass_cnt++;
    @(negedge clk);
    data_addr_ok = 1'b0;
    total_cnt++; if (data_req !== 1'b0 || stall_mem !== 1'b1) $display("[TB] FAIL sh_wait: got req=%b stall=%b want 0/1", data_req, stall_mem); else pass_cnt++;
    data_data_ok = 1'b1;
    @(negedge clk);
    data_data_ok = 1'b0;
    total_cnt++; if (result_valid !== 1'b1) $display("[TB] FAIL sh_valid: got %b want 1", result_valid); else pass_cnt++;
    total_cnt++; if (resultM !== 32'hCAFEF00D) $display("[TB] FAIL sh_result_hold: got %h want cafef00d", resultM); else pass_cnt++;
  endtask

  task automatic test_flush;
    logic rv; logic [31:0] res;
    do_access(EXE_LW_OP, 32'h1000, 4'b0, 32'h0, 32'h12345678, rv, res);
    mem_validE = 1'b1; alucontrolE = EXE_LH_OP; aluoutE = 32'h1000; selE = 4'b0000;
    @(negedge clk);
    mem_validE = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    data_addr_ok = 1'b0; flushM = 1'b1;
    total_cnt++; if (data_req !== 1'b0 || stall_mem !== 1'b1) $display("[TB] FAIL flush_in_wait: got req=%b stall=%b want 0/1", data_req, stall_mem); else pass_cnt++;
    @(negedge clk);
    flushM = 1'b0;
    @(negedge clk);
    data_data_ok = 1'b1; data_rdata = 32'hAAAA5555;
    @(negedge clk);
    data_data_ok = 1'b0;
    total_cnt++; if (result_valid !== 1'b0) $display("[TB] FAIL flush_valid: got %b want 0", result_valid); else pass_cnt++;
    total_cnt++; if (resultM !== 32'h12345678) $display("[TB] FAIL flush_result: got %h want 12345678", resultM); else pass_cnt++;
    total_cnt++; if (stall_mem !== 1'b0) $display("[TB] FAIL flush_idle: got %b want 0", stall_mem); else pass_cnt++;
    do_access(EXE_LW_OP, 32'h1004, 4'b0, 32'h0, 32'h0BADF00D, rv, res);
    total_cnt++; if (rv !== 1'b1 || res !== 32'h0BADF00D) $display("[TB] FAIL flush_next: got %b/%h want 1/0badf00d", rv, res); else pass_cnt++;
    // Flush on the accept cycle blocks the access entirely.
    mem_validE = 1'b1; flushM = 1'b1; alucontrolE = EXE_LW_OP; aluoutE = 32'h1000;
    #1;
    total_cnt++; if (stall_mem !== 1'b0) $display("[TB] FAIL flush_accept_stall: got %b want 0", stall_mem); else pass_cnt++;
    @(negedge clk);
    mem_validE = 1'b0; flushM = 1'b0;
    total_cnt++; if (data_req !== 1'b0) $display("[TB] FAIL flush_accept_req: got %b want 0", data_req); else pass_cnt++;
  endtask

  task automatic test_store_sel_zero;
    mem_validE = 1'b1; alucontrolE = EXE_SW_OP; aluoutE = 32'h2001; selE = 4'b0000; wdataE = 32'h55555555;
    #1;
    total_cnt++; if (stall_mem !== 1'b0) $display("[TB] FAIL sel0_stall: got %b want 0", stall_mem); else pass_cnt++;
    @(negedge clk);
    mem_validE = 1'b0;
    total_cnt++; if (data_req !== 1'b0) $display("[TB] FAIL sel0_req: got %b want 0", data_req); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic rv; logic [31:0] res;
    mem_validE = 1'b1; alucontrolE = EXE_LW_OP; aluoutE = 32'h4000; selE = 4'b0000;
    @(negedge clk);
    mem_validE = 1'b0;
    total_cnt++; if (data_req !== 1'b1) $display("[TB] FAIL rstmid_req_before: got %b want 1", data_req); else pass_cnt++;
    #2 resetn = 1'b0;
    #1;
    total_cnt++; if (data_req !== 1'b0 || stall_mem !== 1'b0) $display("[TB] FAIL rstmid_async: got req=%b stall=%b want 0/0", data_req, stall_mem); else pass_cnt++;
    total_cnt++; if (data_addr !== 32'h0 || resultM !== 32'h0) $display("[TB] FAIL rstmid_regs: got addr=%h res=%h want 0/0", data_addr, resultM); else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    do_access(EXE_LW_OP, 32'h4000, 4'b0, 32'h0, 32'hDEADBEEF, rv, res);
    total_cnt++; if (rv !== 1'b1 || res !== 32'hDEADBEEF) $display("[TB] FAIL rstmid_next: got %b/%h want 1/deadbeef", rv, res); else pass_cnt++;
  endtask

  task automatic test_unaligned;
    mem_validE = 1'b1; alucontrolE = EXE_LW_OP; aluoutE = 32'h1002; selE = 4'b0000;
    #1;
`ifdef MEM_UNALIGN_EXC_EN
    total_cnt++; if (adel !== 1'b1 || ades !== 1'b0) $display("[TB] FAIL unal_adel: got %b/%b want 1/0", adel, ades); else pass_cnt++;
    total_cnt++; if (stall_mem !== 1'b0) $display("[TB] FAIL unal_stall: got %b want 0", stall_mem); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (data_req !== 1'b0) $display("[TB] FAIL unal_req: got %b want 0", data_req); else pass_cnt++;
    alucontrolE = EXE_SH_OP; aluoutE = 32'h2001; selE = 4'b0000;
    #1;
    total_cnt++; if (ades !== 1'b1 || adel !== 1'b0) $display("[TB] FAIL unal_ades: got %b/%b want 1/0", ades, adel); else pass_cnt++;
    @(negedge clk);
    mem_validE = 1'b0;
`else
    total_cnt++; if (adel !== 1'b0 || ades !== 1'b0) $display("[TB] FAIL unal_flags: got %b/%b want 0/0", adel, ades); else pass_cnt++;
    total_cnt++; if (stall_mem !== 1'b1) $display("[TB] FAIL unal_stall: got %b want 1", stall_mem); else pass_cnt++;
    @(negedge clk);
    mem_validE = 1'b0;
    total_cnt++; if (data_addr !== 32'h1000) $display("[TB] FAIL unal_addr: got %h want 00001000", data_addr); else pass_cnt++;
    data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h11223344;
    @(negedge clk);
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    total_cnt++; if (result_valid !== 1'b1 || resultM !== 32'h11223344) $display("[TB] FAIL unal_result: got %b/%h want 1/11223344", result_valid, resultM); else pass_cnt++;
`endif
  endtask

  initial begin
    resetn = 1'b0; mem_validE = 1'b0; alucontrolE = 8'd0; aluoutE = 32'd0;
    selE = 4'd0; wdataE = 32'd0; flushM = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    @(negedge clk);
    test_reset;
    test_lw;
    test_byte_half;
    test_back_to_back;
    test_sh;
    test_flush;
    test_store_sel_zero;
    test_reset_mid;
    test_unaligned;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
